// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM encoding and default width for the bit-serial subtractor
package serial_sub_pkg;

    localparam int SUB_WIDTH_DEFAULT = 8;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN
    } state_t;

endpackage

// File: rtl/full_subtractor_bit.sv
// full_subtractor_bit: one-bit a - b - bin built from two half-subtractor stages
module full_subtractor_bit (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_d1;
    logic w_b1;
    logic w_b2;

    // first stage subtracts b from a, second stage subtracts the incoming borrow
    always_comb begin
        w_d1 = a ^ b;
        w_b1 = ~a & b;
        d    = w_d1 ^ bin;
        w_b2 = ~w_d1 & bin;
        bout = w_b1 | w_b2;
    end

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit diff = a - b, LSB first, start/done handshake.
// Define SERIAL_SUB_SIGNED_OVF_EN to add the two's-complement overflow output ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_res_next;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic             r_a_msb;
    logic             r_b_msb;
`endif

    full_subtractor_bit u_fs (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_br_next)
    );

    assign w_res_next = {w_d, r_res_sh[WIDTH-1:1]};

    // control FSM plus operand/result shift registers; results update only on the final bit
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            ovf      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a_sh   <= a;
                        r_b_sh   <= b;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        r_state  <= S_RUN;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                        r_a_msb  <= a[WIDTH-1];
                        r_b_msb  <= b[WIDTH-1];
`endif
                    end
                end
                S_RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_res_sh <= w_res_next;
                    r_borrow <= w_br_next;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        diff    <= w_res_next;
                        bout    <= w_br_next;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                        ovf     <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: random and directed checks of serial_subtractor against a countdown model
module tb_serial_subtractor;

    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic         ovf;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int n_ops  = 0;

    always #5 CLK = ~CLK;

    serial_subtractor #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // reference: an accepted start produces {bout,diff} = {0,a}-{0,b} exactly W edges later
    bit           m_busy = 0;
    bit           m_done = 0;
    bit           m_bout = 0;
    bit           m_ovf  = 0;
    bit           p_bout = 0;
    bit           p_ovf  = 0;
    logic [W-1:0] m_diff = '0;
    logic [W-1:0] p_diff = '0;
    logic [W:0]   m_r;
    int           m_left = 0;

    always @(posedge CLK) begin
        if (reset) begin
            m_busy = 0; m_done = 0; m_bout = 0; m_ovf = 0; m_diff = '0; m_left = 0;
        end else begin
            m_done = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1;
                    m_diff = p_diff; m_bout = p_bout; m_ovf = p_ovf;
                    n_ops++;
                end
            end else if (start) begin
                m_r    = {1'b0, a} - {1'b0, b};
                p_diff = m_r[W-1:0];
                p_bout = m_r[W];
                p_ovf  = (a[W-1] != b[W-1]) && (m_r[W-1] != a[W-1]);
                m_busy = 1;
                m_left = W;
            end
        end
    end

    always @(negedge CLK) begin
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("diff", diff, m_diff);
        chk("bout", bout, m_bout);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        chk("ovf", ovf, m_ovf);
`endif
    end

    task automatic wait_done(input string name);
        for (int i = 0; i < W + 3 && !done; i++) @(negedge CLK);
        chk({name, "_done_seen"}, done, 1);
    endtask

    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [W-1:0] ed, input logic eb, input logic eo);
        @(negedge CLK);
        start = 1; a = ia; b = ib;
        @(negedge CLK);
        start = 0; a = $urandom; b = $urandom;
        wait_done("op");
        chk("op_diff", diff, ed);
        chk("op_bout", bout, eb);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        chk("op_ovf", ovf, eo);
`else
        if (eo === 1'bx) chk("op_ovf_arg", eo, 0);
`endif
    endtask

    initial begin
        int target;
        int cyc;
        repeat (2) @(negedge CLK);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        reset = 0;

        run_op(8'h05, 8'h03, 8'h02, 0, 0);
        run_op(8'h03, 8'h05, 8'hFE, 1, 0);
        run_op(8'h00, 8'h00, 8'h00, 0, 0);
        run_op(8'hFF, 8'hFF, 8'h00, 0, 0);
        run_op(8'h80, 8'h01, 8'h7F, 0, 1);
        run_op(8'h7F, 8'hFF, 8'h80, 1, 1);

        // start while busy is ignored; start on the done cycle is accepted
        @(negedge CLK);
        start = 1; a = 8'h05; b = 8'h03;
        @(negedge CLK);
        start = 0;
        repeat (2) @(negedge CLK);
        start = 1; a = 8'h10; b = 8'h01;
        @(negedge CLK);
        start = 0;
        wait_done("busy_ign");
        chk("busy_ign_diff", diff, 8'h02);
        chk("busy_ign_bout", bout, 0);
        start = 1; a = 8'h10; b = 8'h01;
        @(negedge CLK);
        start = 0;
        chk("b2b_busy", busy, 1);
        wait_done("b2b");
        chk("b2b_diff", diff, 8'h0F);
        chk("b2b_bout", bout, 0);

        // reset at E4 aborts the operation
        @(negedge CLK);
        start = 1; a = 8'h33; b = 8'h11;
        @(negedge CLK);
        start = 0;
        repeat (3) @(negedge CLK);
        reset = 1;
        @(negedge CLK);
        reset = 0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_diff", diff, 0);
        chk("abort_bout", bout, 0);
        for (int i = 0; i < W + 2; i++) begin
            @(negedge CLK);
            chk("abort_no_done", done, 0);
        end
        run_op(8'h20, 8'h21, 8'hFF, 1, 0);

        // random operands and start timing, including starts while busy
        target = n_ops + 1000;
        cyc = 0;
        while (n_ops < target && cyc < 40000) begin
            @(negedge CLK);
            start = ($urandom_range(0, 1) == 0);
            a = $urandom;
            b = $urandom;
            cyc++;
        end
        chk("random_ops_completed", (n_ops >= target), 1);
        start = 0;
        repeat (W + 2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
